flow_ctrl_hyst: RTL
===================

# flow_ctrl_hyst

Parametrised flow-control block between the FIFO bank and the upstream writers. It registers the four status flags of `NUM_CH` FIFOs and generates one registered enable (`cf`) per channel. A per-channel hysteresis state machine drives each enable: it pauses on almost-full/full and resumes only after the FIFO drains to almost-empty and a minimum pause time has elapsed. It also flags write-on-full overflows and counts pause events.

## Interface
Parameters:
- `NUM_CH`, default 5: number of FIFO channels (≥1).
- `MIN_PAUSE`, default 4: minimum cycles a channel stays paused (≥1).
- `CNT_W`, default 8: width of each per-channel pause-event counter.

Ports:
- `clk`  in  1  single clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `aff`  in  NUM_CH  almost-full flag per FIFO.
- `ff`  in  NUM_CH  full flag per FIFO.
- `aef`  in  NUM_CH  almost-empty flag per FIFO.
- `ef`  in  NUM_CH  empty flag per FIFO.
- `continuar`  in  NUM_CH  upstream enable request per channel (inverse of external pause).
- `push`  in  NUM_CH  write strobe presented to each FIFO; used only for overflow detection.
- `err_clr`  in  1  clears all `overflow` bits.
- `almost_full`, `full`, `almost_empty`, `empty`  out  NUM_CH each  registered copies of `aff`/`ff`/`aef`/`ef`.
- `cf`  out  NUM_CH  registered FIFO write enable per channel.
- `paused`  out  NUM_CH  1 while the channel FSM is in PAUSE.
- `overflow`  out  NUM_CH  sticky write-on-full error.
- `pause_count`  out  NUM_CH*CNT_W  packed saturating RUN→PAUSE counters; channel i occupies bits [i*CNT_W +: CNT_W].

## Operation
- Flag registers: each flag output is its input delayed by one cycle. No other processing.
- Per-channel FSM, states RUN and PAUSE, evaluated on the raw inputs of the current cycle:
  - RUN→PAUSE when `aff[i] | ff[i]`. On entry, the hold counter loads `MIN_PAUSE-1` and `pause_count[i]` increments, saturating at 2^CNT_W−1.
  - In PAUSE, the hold counter decrements by 1 per cycle while nonzero.
  - PAUSE→RUN when the hold counter is 0, `aef[i] | ef[i]` is 1, and `aff[i] | ff[i]` is 0.
  - Otherwise the FSM stays in its current state. Entry conditions take priority over exit conditions.
- `cf[i]` is registered as `continuar[i] & (next_state == RUN)`. `paused[i]` is registered as `(next_state == PAUSE)`.
- Overflow: `overflow[i]` sets when `push[i] & ff[i]` and holds until `err_clr`. If set and clear occur in the same cycle, set wins.
- Inconsistent flags (`ff` and `ef` both high) are treated as full: the channel pauses.
- Channels are fully independent. `pause_count` is cleared only by `reset`.

## Timing
- Reset values, one edge after `reset` = 1:
  - `almost_full` = 0, `full` = 0, `almost_empty` = all 1s, `empty` = all 1s.
  - `cf` = 0, `paused` = 0, `overflow` = 0, `pause_count` = 0.
  - FSMs in RUN, hold counters at 0.
- `reset` overrides all other inputs, including in mid-pause. The first post-reset cycle evaluates normally.
- Latency: every output reflects the inputs sampled at the previous rising edge (1 cycle).
- Minimum PAUSE dwell is `MIN_PAUSE` cycles. With `MIN_PAUSE` = 1, `cf` can drop for a single cycle.
- `continuar[i]` = 0 forces `cf[i]` = 0 on the next edge without changing FSM state.
- Saturation: `pause_count` stays at 2^CNT_W−1 once reached and never wraps.

## Test plan
- Reset then idle: `continuar` = all 1s, all flags 0 except `ef` = all 1s → after reset `cf` = 0, `empty` = 11111; one cycle later `cf` = 11111.
- Pause with hysteresis, `MIN_PAUSE` = 4, channel 2:
  - Assert `aff[2]` for 1 cycle → `cf[2]` = 0 next edge, `paused[2]` = 1, `pause_count[2]` = 1.
  - Deassert `aff[2]` without asserting `aef[2]` → channel stays paused indefinitely.
  - Assert `aef[2]` → `cf[2]` returns to 1 on the next edge, at earliest 4 cycles after entry.
- Minimum dwell: `ff[0]` pulse, then `aef[0]` held high → `cf[0]` low for exactly 4 cycles.
- Overflow: `push[3]` = 1 with `ff[3]` = 1 for one cycle → `overflow[3]` = 1 and held.
  - `err_clr` alone → 0 next edge.
  - `err_clr` together with another overflow → stays 1.
- Saturation with `CNT_W` = 2: five pause/resume cycles on channel 1 → `pause_count[1]` reads 1, 2, 3, 3, 3.
- Reset mid-pause: channel 4 in PAUSE with `overflow[4]` = 1, assert `reset` one cycle → all outputs at reset values, and channel 4 is in RUN.

Source files
------------

// File: rtl/flow_ctrl_hyst.sv
// Flow control between the FIFO bank and upstream writers: registered FIFO flags,
// per-channel RUN/PAUSE hysteresis driving cf, sticky overflow and saturating pause counters.
module flow_ctrl_hyst #(
    parameter int NUM_CH    = 5,
    parameter int MIN_PAUSE = 4,
    parameter int CNT_W     = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_CH-1:0]         aff,
    input  logic [NUM_CH-1:0]         ff,
    input  logic [NUM_CH-1:0]         aef,
    input  logic [NUM_CH-1:0]         ef,
    input  logic [NUM_CH-1:0]         continuar,
    input  logic [NUM_CH-1:0]         push,
    input  logic                      err_clr,
    output logic [NUM_CH-1:0]         almost_full,
    output logic [NUM_CH-1:0]         full,
    output logic [NUM_CH-1:0]         almost_empty,
    output logic [NUM_CH-1:0]         empty,
    output logic [NUM_CH-1:0]         cf,
    output logic [NUM_CH-1:0]         paused,
    output logic [NUM_CH-1:0]         overflow,
    output logic [NUM_CH*CNT_W-1:0]   pause_count
);

    // state   | meaning
    // RUN     | channel may write (cf follows continuar)
    // PAUSE   | writes held off until drained and the hold counter expires
    typedef enum logic {RUN = 1'b0, PAUSE = 1'b1} state_t;

    localparam int HOLD_W = (MIN_PAUSE > 1) ? $clog2(MIN_PAUSE) : 1;

    state_t            state     [NUM_CH];
    state_t            state_nxt [NUM_CH];
    logic [HOLD_W-1:0] hold      [NUM_CH];
    logic [CNT_W-1:0]  cnt       [NUM_CH];

    // Entry (any full-side flag) has priority over exit, so ff+ef together pauses.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            state_nxt[i] = state[i];
            if (state[i] == RUN) begin
                if (aff[i] | ff[i])
                    state_nxt[i] = PAUSE;
            end else if ((hold[i] == '0) && (aef[i] | ef[i]) && !(aff[i] | ff[i])) begin
                state_nxt[i] = RUN;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            almost_full  <= '0;
            full         <= '0;
            almost_empty <= '1;
            empty        <= '1;
            cf           <= '0;
            paused       <= '0;
            overflow     <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                state[i] <= RUN;
                hold[i]  <= '0;
                cnt[i]   <= '0;
            end
        end else begin
            almost_full  <= aff;
            full         <= ff;
            almost_empty <= aef;
            empty        <= ef;
            for (int i = 0; i < NUM_CH; i++) begin
                state[i]  <= state_nxt[i];
                cf[i]     <= continuar[i] & (state_nxt[i] == RUN);
                paused[i] <= (state_nxt[i] == PAUSE);
                if (state[i] == RUN && state_nxt[i] == PAUSE) begin
                    hold[i] <= HOLD_W'(MIN_PAUSE - 1);
                    if (!(&cnt[i]))
                        cnt[i] <= cnt[i] + CNT_W'(1);
                end else if (state[i] == PAUSE && hold[i] != '0) begin
                    hold[i] <= hold[i] - HOLD_W'(1);
                end
                // A new overflow in the clearing cycle must not be lost.
                if (push[i] & ff[i])
                    overflow[i] <= 1'b1;
                else if (err_clr)
                    overflow[i] <= 1'b0;
            end
        end
    end

    always_comb begin
        pause_count = '0;
        for (int i = 0; i < NUM_CH; i++)
            pause_count[i*CNT_W +: CNT_W] = cnt[i];
    end

endmodule
